// File: rtl/el2_ifu_parcel_seq.sv
// el2_ifu_parcel_seq
//
// Parcel sequencer for the IFU decompression path. Fetch words are split into
// two 16-bit parcels and queued in a 3-entry FIFO. The head parcel decides
// whether the next instruction is compressed (one parcel, expanded by the
// external combinational decompressor) or native 32-bit (two parcels).
// One instruction per cycle is presented to decode through a registered
// valid/ready output stage.
//
// Optional feature: define EL2_IFU_SEQ_ILLEGAL_EN to flag compressed parcels
// whose expansion is zero on instr_illegal. Without it instr_illegal is 0.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              drop buffered parcels and the output instruction
//   fw_valid/fw_ready  fetch word handshake, fw_data[15:0] is the older parcel
//   dc_din/dc_dout     head parcel to decompressor / its 32-bit expansion
//   instr_valid/ready  decode handshake
//   instr              expanded or native instruction
//   instr_is_c         instruction came from a 16-bit parcel
//   instr_raw16        original parcel for compressed instructions, else 0
//   instr_illegal      compressed expansion was zero (feature-dependent)
//   c_count            saturating count of compressed instructions emitted
module el2_ifu_parcel_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        fw_valid,
  input  logic [31:0] fw_data,
  output logic        fw_ready,
  output logic [15:0] dc_din,
  input  logic [31:0] dc_dout,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic        instr_is_c,
  output logic [15:0] instr_raw16,
  output logic        instr_illegal,
  output logic [15:0] c_count
);

  logic [15:0] pbuf_q [3];
  logic [15:0] pbuf_d [3];
  logic [1:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic        is_c_q, is_c_d;
  logic [15:0] raw16_q, raw16_d;
  logic [15:0] c_count_q, c_count_d;

  logic        head_is_c;
  logic [1:0]  need;
  logic        out_free;
  logic        emit;
  logic [1:0]  pop;
  logic [1:0]  remain;
  logic        accept;

  assign head_is_c = (pbuf_q[0][1:0] != 2'b11);
  assign need      = head_is_c ? 2'd1 : 2'd2;
  assign out_free  = !valid_q || instr_ready;
  assign emit      = !flush && (cnt_q >= need) && out_free;
  assign pop       = emit ? need : 2'd0;
  assign remain    = cnt_q - pop;
  // Ready looks only at state and instr_ready, never at fw_valid.
  assign fw_ready  = !rst && !flush && (remain <= 2'd1);
  assign accept    = fw_valid && fw_ready;
  assign dc_din    = pbuf_q[0];

  // Buffer: shift out popped parcels, then append the new word behind the rest.
  always_comb begin
    pbuf_d = pbuf_q;
    cnt_d  = remain + (accept ? 2'd2 : 2'd0);
    case (pop)
      2'd1: begin
        pbuf_d[0] = pbuf_q[1];
        pbuf_d[1] = pbuf_q[2];
        pbuf_d[2] = 16'h0;
      end
      2'd2: begin
        pbuf_d[0] = pbuf_q[2];
        pbuf_d[1] = 16'h0;
        pbuf_d[2] = 16'h0;
      end
      default: ;
    endcase
    if (accept) begin
      if (remain == 2'd0) begin
        pbuf_d[0] = fw_data[15:0];
        pbuf_d[1] = fw_data[31:16];
      end else begin
        pbuf_d[1] = fw_data[15:0];
        pbuf_d[2] = fw_data[31:16];
      end
    end
    if (flush) begin
      cnt_d = 2'd0;
      for (int i = 0; i < 3; i++) pbuf_d[i] = 16'h0;
    end
  end

  // Output stage: load on emit, hold while decode stalls.
  always_comb begin
    instr_d   = instr_q;
    is_c_d    = is_c_q;
    raw16_d   = raw16_q;
    c_count_d = c_count_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (emit) begin
      valid_d = 1'b1;
    end else if (instr_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (emit) begin
      is_c_d = head_is_c;
      if (head_is_c) begin
        instr_d = dc_dout;
        raw16_d = pbuf_q[0];
        if (c_count_q != 16'hFFFF) c_count_d = c_count_q + 16'd1;
      end else begin
        instr_d = {pbuf_q[1], pbuf_q[0]};
        raw16_d = 16'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) pbuf_q[i] <= 16'h0;
      cnt_q     <= 2'd0;
      valid_q   <= 1'b0;
      instr_q   <= 32'h0;
      is_c_q    <= 1'b0;
      raw16_q   <= 16'h0;
      c_count_q <= 16'h0;
    end else begin
      pbuf_q    <= pbuf_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      is_c_q    <= is_c_d;
      raw16_q   <= raw16_d;
      c_count_q <= c_count_d;
    end
  end

`ifdef EL2_IFU_SEQ_ILLEGAL_EN
  logic ill_q, ill_d;

  always_comb begin
    ill_d = ill_q;
    if (emit) ill_d = head_is_c && (dc_dout == 32'h0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ill_q <= 1'b0;
    end else begin
      ill_q <= ill_d;
    end
  end

  assign instr_illegal = ill_q;
`else
  assign instr_illegal = 1'b0;
`endif

  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_is_c  = is_c_q;
  assign instr_raw16 = raw16_q;
  assign c_count     = c_count_q;

endmodule

// File: tb/tb_el2_ifu_parcel_seq.sv
module tb_el2_ifu_parcel_seq;

`ifdef EL2_IFU_SEQ_ILLEGAL_EN
  localparam bit IllEn = 1'b1;
`else
  localparam bit IllEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flush;
  logic        fw_valid;
  logic [31:0] fw_data;
  logic        fw_ready;
  logic [15:0] dc_din;
  logic [31:0] dc_dout;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        instr_is_c;
  logic [15:0] instr_raw16;
  logic        instr_illegal;
  logic [15:0] c_count;

  int checks = 0;
  int errors = 0;

  el2_ifu_parcel_seq dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .fw_valid      (fw_valid),
    .fw_data       (fw_data),
    .fw_ready      (fw_ready),
    .dc_din        (dc_din),
    .dc_dout       (dc_dout),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_is_c    (instr_is_c),
    .instr_raw16   (instr_raw16),
    .instr_illegal (instr_illegal),
    .c_count       (c_count)
  );

  // Tiny stand-in for the RVC decompressor: a few real expansions, and a
  // recognisable pattern for every other parcel.
  function automatic logic [31:0] dc_model(input logic [15:0] p);
    case (p)
      16'h808A: dc_model = 32'h002000B3;  // c.mv x1, x2
      16'h0001: dc_model = 32'h00000013;  // c.nop
      16'h0000: dc_model = 32'h00000000;  // illegal
      default:  dc_model = {16'hC0DE, p};
    endcase
  endfunction

  always_comb dc_dout = dc_model(dc_din);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        fw_valid;
    logic [31:0] fw_data;
    logic        instr_ready;
    logic        dc_care;
    logic [15:0] dc_din;
    logic        fw_ready;
    logic        valid;
    logic [31:0] instr;
    logic        is_c;
    logic [15:0] raw16;
    logic        ill;
    logic [15:0] ccount;
  } vec_t;

  vec_t vecs [12];
  logic [15:0] expq [$];
  logic [31:0] words [3];
  int widx;
  int got;

  initial begin
    // in: fw_valid fw_data ready | dc_care dc_din | exp: fw_ready valid instr is_c raw ill cc
    vecs[0]  = '{1'b1, 32'h0001808A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0, 1'b0,
                 16'h0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 32'h0, 1'b1, 1'b1, 16'h808A, 1'b1, 1'b0, 32'h0, 1'b0,
                 16'h0, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 32'h0, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, 32'h002000B3, 1'b1,
                 16'h808A, 1'b0, 16'd1};
    vecs[3]  = '{1'b0, 32'h0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 32'h00000013, 1'b1,
                 16'h0001, 1'b0, 16'd2};
    vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0, 1'b0,
                 16'h0, 1'b0, 16'd2};
    // Straddle: 32-bit instruction split across two fetch words.
    vecs[5]  = '{1'b1, 32'h00B30001, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0, 1'b0,
                 16'h0, 1'b0, 16'd2};
    vecs[6]  = '{1'b1, 32'h00000020, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 32'h0, 1'b0,
                 16'h0, 1'b0, 16'd2};
    vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b1, 16'h00B3, 1'b1, 1'b1, 32'h00000013, 1'b1,
                 16'h0001, 1'b0, 16'd3};
    // Leftover parcel 0x0000 stays buffered while decode stalls.
    vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 32'h002000B3, 1'b0,
                 16'h0000, 1'b0, 16'd3};
    vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 32'h002000B3, 1'b0,
                 16'h0000, 1'b0, 16'd3};
    vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 32'h00000000, 1'b1,
                 16'h0000, 1'b1, 16'd4};
    vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0, 1'b0,
                 16'h0, 1'b0, 16'd4};

    rst         = 1'b1;
    flush       = 1'b0;
    fw_valid    = 1'b0;
    fw_data     = 32'h0;
    instr_ready = 1'b1;

    // Reset held for three rising edges.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_fw_ready", {31'h0, fw_ready}, 32'h0);
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_is_c", {31'h0, instr_is_c}, 32'h0);
      chk("rst_raw16", {16'h0, instr_raw16}, 32'h0);
      chk("rst_illegal", {31'h0, instr_illegal}, 32'h0);
      chk("rst_c_count", {16'h0, c_count}, 32'h0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_fw_ready", {31'h0, fw_ready}, 32'h1);

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      fw_valid    = vecs[i].fw_valid;
      fw_data     = vecs[i].fw_data;
      instr_ready = vecs[i].instr_ready;
      #1;
      chk($sformatf("v%0d_fw_ready", i), {31'h0, fw_ready}, {31'h0, vecs[i].fw_ready});
      chk($sformatf("v%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].valid});
      chk($sformatf("v%0d_c_count", i), {16'h0, c_count}, {16'h0, vecs[i].ccount});
      if (vecs[i].dc_care)
        chk($sformatf("v%0d_dc_din", i), {16'h0, dc_din}, {16'h0, vecs[i].dc_din});
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_instr", i), instr, vecs[i].instr);
        chk($sformatf("v%0d_is_c", i), {31'h0, instr_is_c}, {31'h0, vecs[i].is_c});
        chk($sformatf("v%0d_raw16", i), {16'h0, instr_raw16}, {16'h0, vecs[i].raw16});
        chk($sformatf("v%0d_illegal", i), {31'h0, instr_illegal},
            {31'h0, vecs[i].ill & IllEn});
      end
    end

    // Backpressure on an all-compressed stream.
    words[0] = 32'h00080004;
    words[1] = 32'h0010000C;
    words[2] = 32'h00180014;
    expq = '{16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014, 16'h0018};
    widx = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      fw_valid    = (widx < 3);
      fw_data     = (widx < 3) ? words[widx] : 32'h0;
      instr_ready = !(cyc >= 1 && cyc <= 5);
      #1;
      if (cyc >= 2 && cyc <= 5) chk("bp_fw_ready_low", {31'h0, fw_ready}, 32'h0);
      if (instr_valid) begin
        if (expq.size() == 0) begin
          chk("bp_extra_output", {31'h0, instr_valid}, 32'h0);
        end else begin
          chk("bp_instr", instr, {16'hC0DE, expq[0]});
          chk("bp_raw16", {16'h0, instr_raw16}, {16'h0, expq[0]});
          chk("bp_is_c", {31'h0, instr_is_c}, 32'h1);
          if (instr_ready) begin
            void'(expq.pop_front());
            got++;
          end
        end
      end
      if (fw_valid && fw_ready) widx++;
    end
    chk("bp_outputs_received", got, 6);
    @(negedge clk);
    fw_valid    = 1'b0;
    instr_ready = 1'b1;
    #1;
    chk("bp_c_count", {16'h0, c_count}, 32'd10);
    @(negedge clk);

    // Flush with two parcels buffered and a valid output.
    fw_valid    = 1'b1;
    fw_data     = 32'h00000013;
    instr_ready = 1'b0;
    #1;
    chk("fl_accept_a", {31'h0, fw_ready}, 32'h1);
    @(negedge clk);
    fw_data = 32'h0030002C;
    #1;
    chk("fl_accept_b", {31'h0, fw_ready}, 32'h1);
    @(negedge clk);
    fw_data = 32'h00380034;
    flush   = 1'b1;
    #1;
    chk("fl_valid_before", {31'h0, instr_valid}, 32'h1);
    chk("fl_instr_before", instr, 32'h00000013);
    chk("fl_is_c_before", {31'h0, instr_is_c}, 32'h0);
    chk("fl_fw_ready", {31'h0, fw_ready}, 32'h0);
    @(negedge clk);
    flush       = 1'b0;
    fw_valid    = 1'b0;
    instr_ready = 1'b1;
    #1;
    chk("fl_valid_after", {31'h0, instr_valid}, 32'h0);
    chk("fl_fw_ready_after", {31'h0, fw_ready}, 32'h1);
    chk("fl_c_count", {16'h0, c_count}, 32'd10);
    // Only the new word's parcels may come out after the flush.
    @(negedge clk);
    fw_valid = 1'b1;
    fw_data  = 32'h0040003C;
    #1;
    chk("fl_accept_d", {31'h0, fw_ready}, 32'h1);
    @(negedge clk);
    fw_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("fl_out0_valid", {31'h0, instr_valid}, 32'h1);
    chk("fl_out0_raw16", {16'h0, instr_raw16}, 32'h0000003C);
    chk("fl_out0_instr", instr, 32'hC0DE003C);
    @(negedge clk);
    #1;
    chk("fl_out1_valid", {31'h0, instr_valid}, 32'h1);
    chk("fl_out1_raw16", {16'h0, instr_raw16}, 32'h00000040);
    @(negedge clk);
    #1;
    chk("fl_idle_valid", {31'h0, instr_valid}, 32'h0);
    chk("fl_final_c_count", {16'h0, c_count}, 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
